ball_engine: RTL
================

// Module: ball_engine
// PURPOSE
//  Parametrised pong ball engine: serve/fly/score/win FSM, ball position and scoring.
//  Adds variable speed (accelerates per racket hit), zone-based bounce angle, clamped
//  wall/racket reflection, serve edge detection and a configurable winning score.
//  Sits between the racket controllers and the draw/score-display blocks; ball moves once per frame.
// PARAMETERS
//  X_L_BOUNCE   100   left racket face x (player 2); ball bounces when x <= X_L_BOUNCE
//  X_R_BOUNCE   923   right racket face x (player 1); ball bounces when x >= X_R_BOUNCE-BALL_SIZE
//  Y_TOP        51    top wall y; Y_BOT 717 bottom wall y (ball bounces at Y_BOT-BALL_SIZE)
//  BALL_SIZE    15    ball edge length, px;   RACKET_H  80  racket height, px
//  SPEED_INIT   4     px/frame at serve;  SPEED_STEP 1 added per hit;  SPEED_MAX 15 saturation
//  WIN_POINTS   10    points to win (1..15);  SERVE_X 504, SERVE_Y 376 serve position
//  GLIDE_L      16    SCORE glide stops at x<=GLIDE_L;  GLIDE_R 1007 stops at x>=GLIDE_R
// PORTS
//  clk65MHz      in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  end_of_frame  in   1   1-cycle pulse per frame; only cycle ball state may move
//  serve         in   1   serve button, level; internally rising-edge detected
//  game_en       in   1   game screen active (single or multi); low forces IDLE
//  pos_p1        in  10   top y of right racket (player 1);  pos_p2 in 10 left racket (player 2)
//  ball_x        out 11   ball top-left x;   ball_y  out 11  ball top-left y
//  points_p1     out  4   player 1 score;    points_p2 out 4 player 2 score
//  who_won       out  2   0 none, 1 player 1, 2 player 2
//  hit_pulse     out  1   1-cycle pulse on racket hit;  score_pulse out 1  1-cycle on point award
// BEHAVIOUR
//  Reset: IDLE, ball=(SERVE_X,SERVE_Y), points 0, who_won 0, pulses 0, speed=SPEED_INIT, dx=+1 dy=0.
//  All outputs registered; all position/FSM updates occur in the end_of_frame cycle, visible next cycle.
//  serve_re = serve & ~serve_q (serve_q registered, reset 0); evaluated every cycle, not frame-gated.
//  Velocity: dx in {-1,+1}, dy in {-1,0,+1}, magnitude speed[3:0]; next=pos+d*speed, signed 12-bit math.
//  IDLE : ball at serve pos, points/who_won held 0; game_en=1 -> SERVE.
//  SERVE: ball at serve pos, speed=SPEED_INIT, dy=0; serve_re -> FLY. dx: +1 at game start,
//         else toward player who conceded last point.
//  FLY (per frame): walls: next_y<=Y_TOP -> y=Y_TOP, dy=+1; next_y>=Y_BOT-BALL_SIZE -> clamp, dy=-1.
//   right: dx=+1 and next_x>=X_R_BOUNCE-BALL_SIZE: hit if ball_y+BALL_SIZE>=pos_p1 and
//   ball_y<=pos_p1+RACKET_H -> x clamped to X_R_BOUNCE-BALL_SIZE, dx=-1, hit_pulse,
//   speed=min(speed+SPEED_STEP,SPEED_MAX); dy by ball centre c=ball_y+BALL_SIZE/2 vs racket:
//   c<pos+RACKET_H/3 -> -1, c>=pos+2*RACKET_H/3 -> +1, else 0. Miss -> SCORE, scorer=p2, ball moves.
//   left: mirror with dx=-1, next_x<=X_L_BOUNCE, pos_p2, x clamped to X_L_BOUNCE; miss scorer=p1.
//   Wall and racket in same frame: both applied (corner reflection); racket dy overrides wall dy.
//  SCORE: ball keeps gliding; frame where x<=GLIDE_L or x>=GLIDE_R: x clamped, scorer point +1
//   (saturate 15), score_pulse; new score==WIN_POINTS -> WIN (who_won set same edge) else SERVE.
//  WIN  : ball held at serve pos, points/who_won held; serve_re -> IDLE (points, who_won cleared).
//  game_en=0 in any state -> IDLE next cycle, points and who_won cleared, pulses 0; highest priority
//   after rst. rst mid-flight -> reset values next cycle.
//  Serve held high across WIN->IDLE->SERVE does not re-serve: new rising edge required.
//  Illegal state encoding -> IDLE.
// TESTING
//  rst, game_en=1, serve pulse -> SERVE->FLY; after 1 frame ball_x=508, ball_y=376, hit_pulse 0.
//  Ball dx=+1 at y=376, pos_p1=360 (c=383<386) -> x=908, dx=-1, dy=-1, speed 4->5, hit_pulse 1 cycle.
//  pos_p1=600 on right approach -> SCORE, glide to x>=1007, points_p2 +1, score_pulse, SERVE, dx=+1.
//  Ball y=53, dy=-1, speed 4 -> y=51, dy=+1 next frame; at y=700 dy=+1 -> y=702, dy=-1.
//  points_p1=9, p1 scores -> points_p1=10, who_won=1, WIN; serve_re -> IDLE, points 0, who_won 0.
//  game_en dropped mid-FLY with scores 3:2 -> IDLE next cycle, ball (504,376), points 0:0.

Source files
------------

// File: rtl/ball_engine.sv
// ball_engine: pong ball FSM (serve/fly/score/win) with per-frame motion, accelerating
// speed, zone-based racket bounce, clamped reflections and configurable winning score.
module ball_engine #(
  parameter int X_L_BOUNCE = 100,
  parameter int X_R_BOUNCE = 923,
  parameter int Y_TOP      = 51,
  parameter int Y_BOT      = 717,
  parameter int BALL_SIZE  = 15,
  parameter int RACKET_H   = 80,
  parameter int SPEED_INIT = 4,
  parameter int SPEED_STEP = 1,
  parameter int SPEED_MAX  = 15,
  parameter int WIN_POINTS = 10,
  parameter int SERVE_X    = 504,
  parameter int SERVE_Y    = 376,
  parameter int GLIDE_L    = 16,
  parameter int GLIDE_R    = 1007
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        end_of_frame_i,
  input  logic        serve_i,
  input  logic        game_en_i,
  input  logic [9:0]  pos_p1_i,
  input  logic [9:0]  pos_p2_i,
  output logic [10:0] ball_x_o,
  output logic [10:0] ball_y_o,
  output logic [3:0]  points_p1_o,
  output logic [3:0]  points_p2_o,
  output logic [1:0]  who_won_o,
  output logic        hit_pulse_o,
  output logic        score_pulse_o
);
  typedef enum logic [2:0] {IDLE, SERVE, FLY, SCORE, WIN} state_t;
  localparam logic signed [11:0] XR = 12'(X_R_BOUNCE - BALL_SIZE);
  localparam logic signed [11:0] XL = 12'(X_L_BOUNCE);
  localparam logic signed [11:0] YT = 12'(Y_TOP);
  localparam logic signed [11:0] YB = 12'(Y_BOT - BALL_SIZE);
  localparam logic signed [11:0] GL = 12'(GLIDE_L);
  localparam logic signed [11:0] GR = 12'(GLIDE_R);
  state_t state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic signed [1:0] dy_q, dy_d;
  logic [3:0] spd_q, spd_d, p1_q, p1_d, p2_q, p2_d;
  logic [1:0] won_q, won_d;
  logic dx_q, dx_d, dir_q, dir_d, scorer_q, scorer_d;
  logic hit_q, hit_d, sc_q, sc_d, serve_q;
  logic serve_re, at_r, at_l, hit;
  logic signed [11:0] spd_s, nx, ny;
  logic [10:0] wy;
  logic signed [1:0] wdy;
  logic [11:0] rk, yb;
  logic [4:0] spd_sum;
  logic [3:0] pts, pts_inc;
  // bounce angle from where the ball centre meets the racket (upper/middle/lower third)
  function automatic logic signed [1:0] zone(input logic [11:0] c, input logic [11:0] p);
    return c < p + 12'(RACKET_H / 3) ? -2'sd1 : c >= p + 12'(2 * RACKET_H / 3) ? 2'sd1 : 2'sd0;
  endfunction
  assign serve_re = serve_i & ~serve_q;
  assign spd_s = {8'd0, spd_q};
  assign nx = $signed({1'b0, x_q}) + (dx_q ? spd_s : -spd_s);
  assign ny = $signed({1'b0, y_q}) + (dy_q == 2'sd1 ? spd_s : dy_q == -2'sd1 ? -spd_s : 12'sd0);
  assign wy = ny <= YT ? YT[10:0] : ny >= YB ? YB[10:0] : ny[10:0];
  assign wdy = ny <= YT ? 2'sd1 : ny >= YB ? -2'sd1 : dy_q;
  assign at_r = dx_q && nx >= XR;
  assign at_l = !dx_q && nx <= XL;
  assign rk = {2'b0, at_r ? pos_p1_i : pos_p2_i};
  assign yb = {1'b0, y_q};
  assign hit = (at_r || at_l) && yb + 12'(BALL_SIZE) >= rk && yb <= rk + 12'(RACKET_H);
  assign spd_sum = {1'b0, spd_q} + 5'(SPEED_STEP);
  assign pts = scorer_q ? p1_q : p2_q;
  assign pts_inc = pts == 4'd15 ? pts : pts + 4'd1;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    spd_d = spd_q;
    p1_d = p1_q;
    p2_d = p2_q;
    won_d = won_q;
    dir_d = dir_q;
    scorer_d = scorer_q;
    hit_d = 1'b0;
    sc_d = 1'b0;
    if (state_q != FLY && state_q != SCORE) begin
      x_d = 11'(SERVE_X);
      y_d = 11'(SERVE_Y);
      spd_d = 4'(SPEED_INIT);
      dy_d = 2'sd0;
    end
    case (state_q)
      IDLE: begin
        state_d = SERVE;
        dir_d = 1'b1;
      end
      SERVE: begin
        dx_d = dir_q;
        state_d = serve_re ? FLY : SERVE;
      end
      FLY: if (end_of_frame_i) begin
        x_d = nx[10:0];
        y_d = wy;
        dy_d = wdy;
        if (hit) begin
          x_d = at_r ? XR[10:0] : XL[10:0];
          dx_d = ~dx_q;
          dy_d = zone(yb + 12'(BALL_SIZE / 2), rk);
          spd_d = spd_sum > 5'(SPEED_MAX) ? 4'(SPEED_MAX) : spd_sum[3:0];
          hit_d = 1'b1;
        end else if (at_r || at_l) begin
          state_d = SCORE;
          scorer_d = at_l;
        end
      end
      SCORE: if (end_of_frame_i) begin
        x_d = nx[10:0];
        y_d = wy;
        dy_d = wdy;
        if (nx <= GL || nx >= GR) begin
          x_d = nx <= GL ? GL[10:0] : GR[10:0];
          sc_d = 1'b1;
          p1_d = scorer_q ? pts_inc : p1_q;
          p2_d = scorer_q ? p2_q : pts_inc;
          // next serve travels toward the player who just conceded
          dir_d = ~scorer_q;
          state_d = pts_inc == 4'(WIN_POINTS) ? WIN : SERVE;
          won_d = pts_inc == 4'(WIN_POINTS) ? (scorer_q ? 2'd1 : 2'd2) : won_q;
        end
      end
      WIN: if (serve_re) begin
        state_d = IDLE;
        p1_d = 4'd0;
        p2_d = 4'd0;
        won_d = 2'd0;
      end
      default: state_d = IDLE;
    endcase
    if (!game_en_i) begin
      state_d = IDLE;
      x_d = 11'(SERVE_X);
      y_d = 11'(SERVE_Y);
      dx_d = 1'b1;
      dy_d = 2'sd0;
      spd_d = 4'(SPEED_INIT);
      p1_d = 4'd0;
      p2_d = 4'd0;
      won_d = 2'd0;
      dir_d = 1'b1;
      hit_d = 1'b0;
      sc_d = 1'b0;
    end
  end
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= 11'(SERVE_X);
      y_q <= 11'(SERVE_Y);
      dx_q <= 1'b1;
      dy_q <= 2'sd0;
      spd_q <= 4'(SPEED_INIT);
      p1_q <= 4'd0;
      p2_q <= 4'd0;
      won_q <= 2'd0;
      dir_q <= 1'b1;
      scorer_q <= 1'b0;
      hit_q <= 1'b0;
      sc_q <= 1'b0;
      serve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      spd_q <= spd_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      won_q <= won_d;
      dir_q <= dir_d;
      scorer_q <= scorer_d;
      hit_q <= hit_d;
      sc_q <= sc_d;
      serve_q <= serve_i;
    end
  end
  assign ball_x_o = x_q;
  assign ball_y_o = y_q;
  assign points_p1_o = p1_q;
  assign points_p2_o = p2_q;
  assign who_won_o = won_q;
  assign hit_pulse_o = hit_q;
  assign score_pulse_o = sc_q;
endmodule
